// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the master FSM state type.
//   htrans_t : HTRANS transfer-type codes (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST_* : burst codes used by the master (SINGLE, INCR)
//   HRESP_*  : slave response codes (OKAY, ERROR)
//   state_t  : master FSM states
//   hsize_for: HSIZE value for a given data-bus width
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // IDLE: waiting for a command.
  // XFER: address phases still being issued (overlapping older data phases).
  // LAST: only the final beat's data phase remains.
  // ERR2: waiting out the second cycle of a two-cycle ERROR response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_LAST = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  // HSIZE encodes log2 of the transfer size in bytes.
  function automatic logic [2:0] hsize_for(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: requester-side command/data handshakes plus the
// AHB-Lite master bus, bundled for the ahb_lite_master port list.
//   cmd_*            : command request (valid/ready, write, addr, len)
//   wd_*             : write-data stream into the master
//   rd_valid/rd_data : read beats returned to the requester
//   done/err         : command completion and error status pulses
//   H*               : AHB-Lite master-side bus signals
// Modports: master (the bus master itself), slave (requester + slave mux).
interface ahb_lite_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wd_valid;
  logic [DATA_W-1:0] wd_data;
  logic              wd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wd_valid, wd_data,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, wd_ready, rd_valid, rd_data, done, err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wd_valid, wd_data,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, wd_ready, rd_valid, rd_data, done, err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: turns single commands into pipelined AHB-Lite SINGLE or
// INCR bursts, handling wait states, write-data starvation (BUSY) and the
// two-cycle ERROR response.
//   HCLK   : bus clock, rising edge
//   HRESET : asynchronous active-high reset
//   bus    : ahb_lite_master_if.master (command, write data, read data,
//            completion status and the AHB-Lite master signals)
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_lite_master_if.master bus
);

  state_t            state_reg;
  htrans_t           htrans_reg;
  logic [ADDR_W-1:0] haddr_reg;
  logic              hwrite_reg;
  logic [2:0]        hburst_reg;
  logic [DATA_W-1:0] hwdata_reg;
  logic [DATA_W-1:0] wbuf_reg;      // write data for the beat in its address phase
  logic [DATA_W-1:0] rd_data_reg;
  logic [LEN_W-1:0]  beats_reg;     // beats still to launch after the one on the bus
  logic              dp_active_reg; // a transfer is in its data phase
  logic              dp_write_reg;
  logic              rd_valid_reg;
  logic              done_reg;
  logic              err_reg;
  logic              cmd_ready_reg;

  logic accept;
  logic addr_done;
  logic bus_free;
  logic dp_error;
  logic launch;

  assign accept    = bus.cmd_valid && cmd_ready_reg && (!bus.cmd_write || bus.wd_valid);
  // NONSEQ/SEQ both have bit 1 set; the address phase ends when HREADY is high.
  assign addr_done = bus.HREADY && htrans_reg[1];
  assign bus_free  = (htrans_reg == HTRANS_IDLE) || (htrans_reg == HTRANS_BUSY);
  assign dp_error  = dp_active_reg && (bus.HRESP == HRESP_ERROR);
  // From BUSY the next beat may launch even during a wait state: the pending
  // data phase is unaffected and HADDR already points at the next beat.
  assign launch    = (state_reg == ST_XFER) && (beats_reg != '0) && !dp_error &&
                     (bus.HREADY || bus_free) && (!hwrite_reg || bus.wd_valid);

  assign bus.wd_ready  = (accept && bus.cmd_write) || (launch && hwrite_reg);
  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.HADDR     = haddr_reg;
  assign bus.HTRANS    = htrans_reg;
  assign bus.HWRITE    = hwrite_reg;
  assign bus.HSIZE     = hsize_for(DATA_W);
  assign bus.HBURST    = hburst_reg;
  assign bus.HWDATA    = hwdata_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg     <= ST_IDLE;
      htrans_reg    <= HTRANS_IDLE;
      haddr_reg     <= '0;
      hwrite_reg    <= 1'b0;
      hburst_reg    <= HBURST_SINGLE;
      hwdata_reg    <= '0;
      wbuf_reg      <= '0;
      rd_data_reg   <= '0;
      beats_reg     <= '0;
      dp_active_reg <= 1'b0;
      dp_write_reg  <= 1'b0;
      rd_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cmd_ready_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            haddr_reg     <= bus.cmd_addr;
            htrans_reg    <= HTRANS_NONSEQ;
            hwrite_reg    <= bus.cmd_write;
            hburst_reg    <= (bus.cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
            beats_reg     <= bus.cmd_len;
            dp_active_reg <= 1'b0;
            if (bus.cmd_write) wbuf_reg <= bus.wd_data;
            cmd_ready_reg <= 1'b0;
            state_reg     <= ST_XFER;
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end

        ST_XFER, ST_LAST: begin
          if (dp_error) begin
            // Any pending address phase is cancelled; its buffered data is dropped.
            htrans_reg <= HTRANS_IDLE;
            beats_reg  <= '0;
            if (bus.HREADY) begin
              done_reg      <= 1'b1;
              err_reg       <= 1'b1;
              dp_active_reg <= 1'b0;
              cmd_ready_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end else begin
              state_reg <= ST_ERR2;
            end
          end else begin
            if (bus.HREADY) begin
              if (dp_active_reg && !dp_write_reg) begin
                rd_valid_reg <= 1'b1;
                rd_data_reg  <= bus.HRDATA;
              end
              dp_active_reg <= addr_done;
              dp_write_reg  <= hwrite_reg;
              if (addr_done && hwrite_reg) hwdata_reg <= wbuf_reg;
              if (state_reg == ST_LAST && dp_active_reg) begin
                done_reg      <= 1'b1;
                cmd_ready_reg <= 1'b1;
                state_reg     <= ST_IDLE;
              end
            end

            if (launch) begin
              htrans_reg <= HTRANS_SEQ;
              if (htrans_reg[1]) haddr_reg <= haddr_reg + 1'b1;
              beats_reg  <= beats_reg - 1'b1;
              if (hwrite_reg) wbuf_reg <= bus.wd_data;
            end else if (state_reg == ST_XFER && addr_done) begin
              if (beats_reg == '0) begin
                htrans_reg <= HTRANS_IDLE;
                state_reg  <= ST_LAST;
              end else begin
                // Write data starved: park on the next address with BUSY.
                htrans_reg <= HTRANS_BUSY;
                haddr_reg  <= haddr_reg + 1'b1;
              end
            end
          end
        end

        ST_ERR2: begin
          if (bus.HREADY) begin
            done_reg      <= 1'b1;
            err_reg       <= 1'b1;
            dp_active_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed bench for ahb_lite_master. A small slave model
// returns mem[data-phase address] on HRDATA; HREADY/HRESP are driven per cycle
// by each directed test. Expected values are hand-computed constants.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_if bus ();

  ahb_lite_master dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  // Slave model: remember the address whose data phase is in progress.
  logic [7:0] mem [16];
  logic [3:0] dp_addr = 4'h0;
  always @(posedge HCLK) begin
    if (bus.HREADY && bus.HTRANS[1]) dp_addr <= bus.HADDR;
  end
  assign bus.HRDATA = mem[dp_addr];

  int rd_cnt = 0;
  int done_cnt = 0;
  always @(negedge HCLK) begin
    if (bus.rd_valid === 1'b1) rd_cnt <= rd_cnt + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic single_read(input logic [3:0] addr, input logic [7:0] exp, input string tag);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = addr; bus.cmd_len = 4'd0;
    tick(); bus.cmd_valid = 1'b0;
    check_eq({tag, ".htrans_nonseq"}, bus.HTRANS, HTRANS_NONSEQ);
    check_eq({tag, ".haddr"}, bus.HADDR, addr);
    check_eq({tag, ".hburst_single"}, bus.HBURST, 3'b000);
    check_eq({tag, ".hwrite"}, bus.HWRITE, 1'b0);
    check_eq({tag, ".cmd_ready_busy"}, bus.cmd_ready, 1'b0);
    tick();
    check_eq({tag, ".htrans_idle"}, bus.HTRANS, HTRANS_IDLE);
    check_eq({tag, ".rd_valid_early"}, bus.rd_valid, 1'b0);
    tick();
    check_eq({tag, ".rd_valid"}, bus.rd_valid, 1'b1);
    check_eq({tag, ".rd_data"}, bus.rd_data, exp);
    check_eq({tag, ".done"}, bus.done, 1'b1);
    check_eq({tag, ".err"}, bus.err, 1'b0);
    tick();
    check_eq({tag, ".done_clear"}, bus.done, 1'b0);
    check_eq({tag, ".cmd_ready"}, bus.cmd_ready, 1'b1);
    $display("[%0t] txn %s: single read addr=0x%0h data=0x%0h", $time, tag, addr, bus.rd_data);
  endtask

  int base;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {i[3:0], i[3:0]};
    mem[0] = 8'hA0;
    mem[9] = 8'h5A;
    HRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst.htrans", bus.HTRANS, HTRANS_IDLE);
    check_eq("rst.haddr", bus.HADDR, 4'h0);
    check_eq("rst.hwdata", bus.HWDATA, 8'h00);
    check_eq("rst.cmd_ready", bus.cmd_ready, 1'b0);
    check_eq("rst.done", bus.done, 1'b0);
    check_eq("rst.wd_ready", bus.wd_ready, 1'b0);
    HRESET = 1'b0;
    tick();
    check_eq("rst.cmd_ready_after", bus.cmd_ready, 1'b1);
    $display("[%0t] txn reset released", $time);

    // Single read at 0x9
    single_read(4'h9, 8'h5A, "rd1");

    // INCR write of 4 beats from 0xE, wrapping past 0xF
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'hE; bus.cmd_len = 4'd3;
    bus.wd_valid = 1'b1; bus.wd_data = 8'h11;
    #1 check_eq("wr4.wd_ready_accept", bus.wd_ready, 1'b1);
    tick(); bus.cmd_valid = 1'b0; bus.wd_data = 8'h22;
    check_eq("wr4.b0_htrans", bus.HTRANS, HTRANS_NONSEQ);
    check_eq("wr4.b0_haddr", bus.HADDR, 4'hE);
    check_eq("wr4.hburst_incr", bus.HBURST, 3'b001);
    check_eq("wr4.hwrite", bus.HWRITE, 1'b1);
    tick(); bus.wd_data = 8'h33;
    check_eq("wr4.b1_htrans", bus.HTRANS, HTRANS_SEQ);
    check_eq("wr4.b1_haddr", bus.HADDR, 4'hF);
    check_eq("wr4.hwdata0", bus.HWDATA, 8'h11);
    tick(); bus.wd_data = 8'h44;
    check_eq("wr4.b2_haddr_wrap", bus.HADDR, 4'h0);
    check_eq("wr4.hwdata1", bus.HWDATA, 8'h22);
    tick(); bus.wd_valid = 1'b0;
    check_eq("wr4.b3_htrans", bus.HTRANS, HTRANS_SEQ);
    check_eq("wr4.b3_haddr", bus.HADDR, 4'h1);
    check_eq("wr4.hwdata2", bus.HWDATA, 8'h33);
    tick();
    check_eq("wr4.htrans_idle", bus.HTRANS, HTRANS_IDLE);
    check_eq("wr4.hwdata3", bus.HWDATA, 8'h44);
    tick();
    check_eq("wr4.done", bus.done, 1'b1);
    check_eq("wr4.err", bus.err, 1'b0);
    check_eq("wr4.no_rd_valid", bus.rd_valid, 1'b0);
    $display("[%0t] txn wr4: write E..1 data 11,22,33,44", $time);

    // Read of 2 beats from 0x6 with two wait states on the first data phase
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h6; bus.cmd_len = 4'd1;
    tick(); bus.cmd_valid = 1'b0;
    check_eq("rdw.b0_haddr", bus.HADDR, 4'h6);
    tick(); bus.HREADY = 1'b0;
    check_eq("rdw.b1_htrans_w0", bus.HTRANS, HTRANS_SEQ);
    check_eq("rdw.b1_haddr_w0", bus.HADDR, 4'h7);
    tick();
    check_eq("rdw.b1_haddr_w1", bus.HADDR, 4'h7);
    check_eq("rdw.rd_valid_wait", bus.rd_valid, 1'b0);
    tick(); bus.HREADY = 1'b1;
    check_eq("rdw.b1_htrans_w2", bus.HTRANS, HTRANS_SEQ);
    check_eq("rdw.b1_haddr_w2", bus.HADDR, 4'h7);
    tick();
    check_eq("rdw.htrans_idle", bus.HTRANS, HTRANS_IDLE);
    check_eq("rdw.rd_valid0", bus.rd_valid, 1'b1);
    check_eq("rdw.rd_data0", bus.rd_data, 8'h66);
    tick();
    check_eq("rdw.rd_valid1", bus.rd_valid, 1'b1);
    check_eq("rdw.rd_data1", bus.rd_data, 8'h77);
    check_eq("rdw.done", bus.done, 1'b1);
    $display("[%0t] txn rdw: read 6,7 with wait states", $time);

    // Write of 3 beats from 0x3 with write data starved for two cycles
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'h3; bus.cmd_len = 4'd2;
    bus.wd_valid = 1'b1; bus.wd_data = 8'hA1;
    tick(); bus.cmd_valid = 1'b0; bus.wd_valid = 1'b0;
    check_eq("wrb.b0_htrans", bus.HTRANS, HTRANS_NONSEQ);
    #1 check_eq("wrb.wd_ready_starved", bus.wd_ready, 1'b0);
    tick();
    check_eq("wrb.busy0_htrans", bus.HTRANS, HTRANS_BUSY);
    check_eq("wrb.busy0_haddr", bus.HADDR, 4'h4);
    check_eq("wrb.hwdata0", bus.HWDATA, 8'hA1);
    tick(); bus.wd_valid = 1'b1; bus.wd_data = 8'hB2;
    check_eq("wrb.busy1_htrans", bus.HTRANS, HTRANS_BUSY);
    check_eq("wrb.busy1_haddr", bus.HADDR, 4'h4);
    #1 check_eq("wrb.wd_ready_resume", bus.wd_ready, 1'b1);
    tick(); bus.wd_data = 8'hC3;
    check_eq("wrb.b1_htrans", bus.HTRANS, HTRANS_SEQ);
    check_eq("wrb.b1_haddr", bus.HADDR, 4'h4);
    tick(); bus.wd_valid = 1'b0;
    check_eq("wrb.b2_haddr", bus.HADDR, 4'h5);
    check_eq("wrb.hwdata1", bus.HWDATA, 8'hB2);
    tick();
    check_eq("wrb.htrans_idle", bus.HTRANS, HTRANS_IDLE);
    check_eq("wrb.hwdata2", bus.HWDATA, 8'hC3);
    tick();
    check_eq("wrb.done", bus.done, 1'b1);
    $display("[%0t] txn wrb: write 3..5 with BUSY stall", $time);

    // Read of 4 beats from 0x0; beat 1 gets a two-cycle ERROR
    base = rd_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h0; bus.cmd_len = 4'd3;
    tick(); bus.cmd_valid = 1'b0;
    check_eq("rde.b0_haddr", bus.HADDR, 4'h0);
    tick();
    check_eq("rde.b1_haddr", bus.HADDR, 4'h1);
    tick(); bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    check_eq("rde.b2_htrans", bus.HTRANS, HTRANS_SEQ);
    check_eq("rde.rd_data0", bus.rd_data, 8'hA0);
    tick(); bus.HREADY = 1'b1;
    check_eq("rde.htrans_cancel", bus.HTRANS, HTRANS_IDLE);
    check_eq("rde.done_early", bus.done, 1'b0);
    tick(); bus.HRESP = 1'b0;
    check_eq("rde.done", bus.done, 1'b1);
    check_eq("rde.err", bus.err, 1'b1);
    check_eq("rde.rd_valid_err", bus.rd_valid, 1'b0);
    tick();
    check_eq("rde.err_clear", bus.err, 1'b0);
    check_eq("rde.htrans_after", bus.HTRANS, HTRANS_IDLE);
    check_eq("rde.rd_count", rd_cnt - base, 1);
    $display("[%0t] txn rde: read with ERROR on beat 1", $time);

    // Reset asserted in the middle of a read burst
    base = done_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h8; bus.cmd_len = 4'd3;
    tick(); bus.cmd_valid = 1'b0;
    tick(); tick();
    check_eq("mrst.pre_haddr", bus.HADDR, 4'hA);
    check_eq("mrst.pre_rd_valid", bus.rd_valid, 1'b1);
    HRESET = 1'b1;
    #1;
    check_eq("mrst.htrans", bus.HTRANS, HTRANS_IDLE);
    check_eq("mrst.haddr", bus.HADDR, 4'h0);
    check_eq("mrst.hburst", bus.HBURST, 3'b000);
    check_eq("mrst.hwdata", bus.HWDATA, 8'h00);
    check_eq("mrst.rd_valid", bus.rd_valid, 1'b0);
    check_eq("mrst.rd_data", bus.rd_data, 8'h00);
    check_eq("mrst.cmd_ready", bus.cmd_ready, 1'b0);
    tick(); tick();
    HRESET = 1'b0;
    tick();
    check_eq("mrst.no_done", done_cnt - base, 0);
    check_eq("mrst.cmd_ready_after", bus.cmd_ready, 1'b1);
    $display("[%0t] txn mrst: reset mid-burst", $time);
    single_read(4'h9, 8'h5A, "rd2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
